// File: rtl/uart_tx_pkg.sv
// Shared UART packages: build-time defaults and the transmitter state encoding.
package config_pkg;
  localparam int UartClksPerBit = 104;
  localparam int UartStopBits   = 1;
endpackage

package decoder_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;
endpackage

// File: rtl/baud_tick_gen.sv
// Baud counter: counts 0..ClksPerBit-1 while running and flags the last cycle
// of each bit period. Shared with the receiver.
module baud_tick_gen #(
  parameter int ClksPerBit = 104
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic run_i,
  output logic tick_o
);
  localparam int CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(ClksPerBit - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = run_i && (cnt_q == CntMax);

  // Next count: clear wins, otherwise advance and wrap only while running.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)    cnt_d = '0;
    else if (run_i) cnt_d = tick_o ? '0 : cnt_q + CntW'(1);
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_tx.sv
// 8N1/8N2 serial transmitter draining the UART byte FIFO. Pops one byte per
// frame and supports back-to-back frames with no idle gap. All outputs are
// flops so the pad sees no combinational path from any input.
module uart_tx
  import config_pkg::*;
  import decoder_pkg::*;
#(
  parameter int ClksPerBit = UartClksPerBit,
  parameter int StopBits   = UartStopBits
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       enable_i,
  input  logic [7:0] data_i,
  input  logic       have_next_i,
  output logic       next_o,
  output logic       tx_o,
  output logic       busy_o
);
  // bit_cnt doubles as the stop-bit counter inside STOP.
  localparam logic [2:0] LastStop = 3'(StopBits - 1);

  uart_tx_state_t state_q, state_d;
  logic [7:0]     shreg_q, shreg_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic           tx_q, tx_d;
  logic           next_q, next_d;
  logic           busy_q, busy_d;
  logic           start;
  logic           tick;

  baud_tick_gen #(.ClksPerBit(ClksPerBit)) u_baud (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(start),
    .run_i  (state_q != IDLE),
    .tick_o (tick)
  );

  // Next-state, shifter and registered-output decode.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    start     = 1'b0;
    unique case (state_q)
      IDLE:  if (have_next_i && enable_i) start = 1'b1;
      START: if (tick) state_d = DATA;
      DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == 3'd7) begin
            state_d   = STOP;
            bit_cnt_d = 3'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_cnt_q == LastStop) begin
            if (have_next_i && enable_i) start = 1'b1;
            else                         state_d = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Frame start (from IDLE or straight out of the last stop cycle).
    if (start) begin
      state_d   = START;
      shreg_d   = data_i;
      bit_cnt_d = 3'd0;
    end
    // Line level follows the state being entered so tx changes with it.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
    next_d = start;
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drives the line idle-high immediately.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      shreg_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      tx_q      <= 1'b1;
      next_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      next_q    <= next_d;
      busy_q    <= busy_d;
    end
  end

  assign tx_o   = tx_q;
  assign next_o = next_q;
  assign busy_o = busy_q;
endmodule
